// File: rtl/fwft_fifo_pkg.sv
// Shared helpers and types for the fwft_fifo_flex family.
// Pointer wrap helper, statistics counter width and a debug status encoding.
package fwft_fifo_pkg;

    localparam int STAT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_status_e;

    // Explicit wrap keeps pointers valid for depths that are not a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fwft_fifo_flex_ram.sv
// Simple dual-port storage for fwft_fifo_flex: registered write, asynchronous read.
// The combinational read is what lets a freshly written head word fall through.
module fwft_fifo_flex_ram #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
    input  logic [FIFO_WIDTH-1:0]         wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [FIFO_WIDTH-1:0]         rd_data
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fwft_fifo_flex.sv
// First-word-fall-through single-clock FIFO with any-integer depth, occupancy, flags and error pulses.
// Define FWFT_FIFO_FLEX_STATS_EN to add the max_used high-water mark and ovf_cnt outputs.
module fwft_fifo_flex
    import fwft_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_ADDR  = $clog2(FIFO_DEPTH),
    parameter int AFULL_LVL  = FIFO_DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    input  logic                  flush,
    output logic [FIFO_ADDR:0]    used_words,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef FWFT_FIFO_FLEX_STATS_EN
    ,
    output logic [FIFO_ADDR:0]    max_used,
    output logic [STAT_CNT_W-1:0] ovf_cnt
`endif
);

    localparam int CW = FIFO_ADDR + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [FIFO_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        used_q, used_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 afull_q, afull_d;
    logic                 aempty_q, aempty_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 wr_acc, rd_acc;

    // Flush suppresses both acceptance and the error pulses for that cycle.
    assign wr_acc = wr_en && !full_q && !flush;
    assign rd_acc = rd_en && !empty_q && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        ovf_d    = wr_en && full_q && !flush;
        unf_d    = rd_en && empty_q && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = FIFO_ADDR'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_d = FIFO_ADDR'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   used_d = used_q + CW'(1);
                2'b01:   used_d = used_q - CW'(1);
                default: used_d = used_q;
            endcase
        end
        full_d   = (used_d == DEPTH_C);
        empty_d  = (used_d == '0);
        afull_d  = (used_d >= AFULL_C);
        aempty_d = (used_d <= AEMPTY_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fwft_fifo_flex_ram #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_addr (rd_ptr_q),
        .rd_data (dout)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign used_words   = used_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

`ifdef FWFT_FIFO_FLEX_STATS_EN
    logic [CW-1:0]         max_used_q, max_used_d;
    logic [STAT_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // High-water mark survives flush; only reset clears it.
    always_comb begin
        max_used_d = (used_d > max_used_q) ? used_d : max_used_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + STAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_used_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            max_used_q <= max_used_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign max_used = max_used_q;
    assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fwft_fifo_flex.sv
// Self-checking bench for fwft_fifo_flex (depth 5, width 8, afull 4, aempty 1):
// directed literal checks plus randomized traffic against a queue model.
module tb_fwft_fifo_flex;

    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] din = '0;
    logic         rd_en = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dout;
    logic         full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]   used_words;
`ifdef FWFT_FIFO_FLEX_STATS_EN
    logic [3:0]   max_used;
    logic [15:0]  ovf_cnt;
`endif

    fwft_fifo_flex #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .AFULL_LVL  (AF),
        .AEMPTY_LVL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .flush        (flush),
        .used_words   (used_words),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FWFT_FIFO_FLEX_STATS_EN
        ,
        .max_used     (max_used),
        .ovf_cnt      (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Reference model: contents as a queue, error pulses and statistics as plain values.
    logic [W-1:0] mq[$];
    bit           e_ovf = 1'b0;
    bit           e_unf = 1'b0;
    int           e_max = 0;
    int           e_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                        input logic f, input logic rs);
        int sz;
        wr_en = w; din = d; rd_en = r; flush = f; rst = rs;
        @(posedge clk);
        sz = mq.size();
        if (rs) begin
            mq.delete(); e_ovf = 1'b0; e_unf = 1'b0; e_max = 0; e_cnt = 0;
        end else if (f) begin
            mq.delete(); e_ovf = 1'b0; e_unf = 1'b0;
        end else begin
            e_ovf = w && (sz == DEPTH);
            e_unf = r && (sz == 0);
            if (r && sz > 0) void'(mq.pop_front());
            if (w && sz < DEPTH) mq.push_back(d);
            if (e_ovf && e_cnt != 16'hFFFF) e_cnt++;
        end
        if (!rs && mq.size() > e_max) e_max = mq.size();
        $display("txn t=%0t wr=%0b din=%02h rd=%0b flush=%0b rst=%0b -> model used=%0d",
                 $time, w, d, r, f, rs, mq.size());
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("empty", int'(empty), int'(mq.size() == 0));
            check("full", int'(full), int'(mq.size() == DEPTH));
            check("used_words", int'(used_words), mq.size());
            check("almost_full", int'(almost_full), int'(mq.size() >= AF));
            check("almost_empty", int'(almost_empty), int'(mq.size() <= AE));
            check("overflow", int'(overflow), int'(e_ovf));
            check("underflow", int'(underflow), int'(e_unf));
            if (mq.size() > 0) check("dout", int'(dout), int'(mq[0]));
`ifdef FWFT_FIFO_FLEX_STATS_EN
            check("max_used", int'(max_used), e_max);
            check("ovf_cnt", int'(ovf_cnt), e_cnt);
`endif
        end
    end

    initial begin
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk_en = 1'b1;
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_used", int'(used_words), 0);
        check("rst_aempty", int'(almost_empty), 1);
        check("rst_afull", int'(almost_full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_unf", int'(underflow), 0);

        // FWFT: word visible right after its write edge
        step(1, 8'hA5, 0, 0, 0);
        check("fwft_dout", int'(dout), 8'hA5);
        check("fwft_empty", int'(empty), 0);
        step(0, 8'h00, 1, 0, 0);
        check("fwft_pop_empty", int'(empty), 1);

        // Fill to full with threshold literals along the way
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(8'h10 + i), 0, 0, 0);
            check("fill_used", int'(used_words), i + 1);
            check("fill_afull", int'(almost_full), int'(i + 1 >= 4));
            check("fill_aempty", int'(almost_empty), int'(i + 1 <= 1));
        end
        check("fill_full", int'(full), 1);

        // Overflow pulse, dropped word
        step(1, 8'hFF, 0, 0, 0);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_used", int'(used_words), 5);
        step(0, 8'h00, 0, 0, 0);
        check("ovf_clear", int'(overflow), 0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_dout", int'(dout), 8'h10 + i);
            step(0, 8'h00, 1, 0, 0);
        end
        check("drain_empty", int'(empty), 1);

        // Underflow pulse
        step(0, 8'h00, 1, 0, 0);
        check("unf_pulse", int'(underflow), 1);
        step(0, 8'h00, 0, 0, 0);
        check("unf_clear", int'(underflow), 0);

        // Simultaneous read+write at 3 words
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'h23, 1, 0, 0);
        check("rw3_used", int'(used_words), 3);
        check("rw3_dout", int'(dout), 8'h21);
        for (int i = 0; i < 3; i++) begin
            check("rw3_order", int'(dout), 8'h21 + i);
            step(0, 8'h00, 1, 0, 0);
        end

        // Simultaneous read+write while empty
        step(1, 8'h30, 1, 0, 0);
        check("rw0_unf", int'(underflow), 1);
        check("rw0_used", int'(used_words), 1);
        check("rw0_dout", int'(dout), 8'h30);
        step(0, 8'h00, 1, 0, 0);

        // Wrap pointers, refill to full, then flush with wr_en asserted
        for (int i = 0; i < 12; i++) begin
            step(1, 8'(8'h40 + i), 0, 0, 0);
            step(0, 8'h00, 1, 0, 0);
        end
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        step(1, 8'hEE, 0, 1, 0);
        check("flush_empty", int'(empty), 1);
        check("flush_used", int'(used_words), 0);
        check("flush_ovf", int'(overflow), 0);
        step(1, 8'h55, 0, 0, 0);
        check("post_flush_dout", int'(dout), 8'h55);

        // Reset mid-fill
        step(1, 8'h71, 0, 0, 0);
        step(1, 8'h72, 0, 0, 1);
        check("rst_mid_empty", int'(empty), 1);
        check("rst_mid_used", int'(used_words), 0);
        step(1, 8'h73, 0, 0, 0);
        check("rst_mid_dout", int'(dout), 8'h73);

        // Randomized 50/50 traffic with occasional flush and reset
        for (int i = 0; i < 20000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 511) == 0));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
